// File: rtl/pbs_pkg.sv
// Shared types and constants for the attack resolver: FSM states, default
// sizing, LFSR seed and the feedback tap mask.
package pbs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROLL,
        ST_APPLY,
        ST_REPORT,
        ST_OVER
    } state_t;

    localparam int         DEF_HP_W      = 8;
    localparam int         DEF_MAX_HP    = 40;
    localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pbs_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; shifts on every clock, reloads SEED on reset.
module pbs_lfsr8
    import pbs_pkg::*;
#(
    parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/attack_resolver.sv
// Turn-based attack resolution: roll hit against an LFSR, saturate-subtract HP,
// strobe the result, alternate turns. Optional critical hits via PBS_CRIT_EN.
module attack_resolver
    import pbs_pkg::*;
#(
    parameter int         HP_W      = DEF_HP_W,
    parameter int         MAX_HP    = DEF_MAX_HP,
    parameter logic [7:0] LFSR_SEED = DEF_LFSR_SEED
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            new_game,
    input  logic            atk_valid,
    output logic            atk_ready,
    input  logic [3:0]      dmg,
    input  logic [3:0]      accu,
    output logic            turn,
    output logic [HP_W-1:0] p1_hp,
    output logic [HP_W-1:0] p2_hp,
    output logic            res_valid,
    output logic            res_hit,
    output logic            res_crit,
    output logic [4:0]      res_dmg,
    output logic            game_over,
    output logic            winner
);

    localparam logic [HP_W-1:0] HP_INIT = HP_W'(MAX_HP);

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [4:0]      b);
        logic [HP_W:0] diff;
        diff = {1'b0, a} - {{(HP_W-4){1'b0}}, b};
        return diff[HP_W] ? '0 : diff[HP_W-1:0];
    endfunction

    state_t          r_state;
    logic [HP_W-1:0] r_p1_hp;
    logic [HP_W-1:0] r_p2_hp;
    logic            r_turn;
    logic            r_res_valid;
    logic            r_res_hit;
    logic [4:0]      r_res_dmg;
    logic            r_game_over;
    logic            r_winner;

    logic [3:0]      r_dmg_p0;
    logic [3:0]      r_accu_p0;
    logic            r_hit_p1;
    logic [4:0]      r_req_p1;

    logic [7:0]      w_lfsr;
    logic            w_hit;
    logic            w_crit;
    logic [4:0]      w_req;
    logic [HP_W-1:0] w_def_hp;

    pbs_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_lfsr (w_lfsr)
    );

    always_comb begin
        w_hit = (w_lfsr[3:0] <= r_accu_p0);
`ifdef PBS_CRIT_EN
        w_crit = w_hit && (w_lfsr[7:4] == 4'hF);
`else
        w_crit = 1'b0;
`endif
        if (!w_hit) begin
            w_req = 5'd0;
        end else if (w_crit) begin
            w_req = {r_dmg_p0, 1'b0};
        end else begin
            w_req = {1'b0, r_dmg_p0};
        end
    end

`ifndef PBS_CRIT_EN
    logic [3:0] w_unused_lfsr_hi;
    assign w_unused_lfsr_hi = w_lfsr[7:4];
`endif

    // Defender is the player not holding the turn; read after APPLY updated it.
    assign w_def_hp = r_turn ? r_p1_hp : r_p2_hp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_p1_hp     <= HP_INIT;
            r_p2_hp     <= HP_INIT;
            r_turn      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_dmg   <= 5'd0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
        end else if (new_game) begin
            r_state     <= ST_IDLE;
            r_p1_hp     <= HP_INIT;
            r_p2_hp     <= HP_INIT;
            r_turn      <= 1'b0;
            r_res_valid <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (atk_valid) begin
                        r_state <= ST_ROLL;
                    end
                end
                ST_ROLL: begin
                    r_state <= ST_APPLY;
                end
                ST_APPLY: begin
                    if (r_turn) begin
                        r_p1_hp <= sat_sub(r_p1_hp, r_req_p1);
                    end else begin
                        r_p2_hp <= sat_sub(r_p2_hp, r_req_p1);
                    end
                    r_res_valid <= 1'b1;
                    r_res_hit   <= r_hit_p1;
                    r_res_dmg   <= r_req_p1;
                    r_state     <= ST_REPORT;
                end
                ST_REPORT: begin
                    r_turn <= ~r_turn;
                    if (w_def_hp == '0) begin
                        r_game_over <= 1'b1;
                        r_winner    <= r_turn;
                        r_state     <= ST_OVER;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OVER: begin
                    r_state <= ST_OVER;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage p0: move captured on acceptance. Stage p1: roll result.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && atk_valid) begin
            r_dmg_p0  <= dmg;
            r_accu_p0 <= accu;
        end
        if (r_state == ST_ROLL) begin
            r_hit_p1 <= w_hit;
            r_req_p1 <= w_req;
        end
    end

`ifdef PBS_CRIT_EN
    logic r_crit_p1;
    logic r_res_crit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crit_p1  <= 1'b0;
            r_res_crit <= 1'b0;
        end else if (!new_game) begin
            if (r_state == ST_ROLL) begin
                r_crit_p1 <= w_crit;
            end
            if (r_state == ST_APPLY) begin
                r_res_crit <= r_crit_p1;
            end
        end
    end

    assign res_crit = r_res_crit;
`else
    assign res_crit = 1'b0;
`endif

    assign atk_ready = (r_state == ST_IDLE);
    assign turn      = r_turn;
    assign p1_hp     = r_p1_hp;
    assign p2_hp     = r_p2_hp;
    assign res_valid = r_res_valid;
    assign res_hit   = r_res_hit;
    assign res_dmg   = r_res_dmg;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule

// File: tb/tb_attack_resolver.sv
// Directed + randomized bench for attack_resolver against a turn-level game model.
module tb_attack_resolver;

`ifdef PBS_CRIT_EN
    localparam bit CRIT_EN = 1'b1;
`else
    localparam bit CRIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic       atk_valid = 1'b0;
    logic       atk_ready;
    logic [3:0] dmg = 4'd0;
    logic [3:0] accu = 4'd0;
    logic       turn;
    logic [7:0] p1_hp;
    logic [7:0] p2_hp;
    logic       res_valid;
    logic       res_hit;
    logic       res_crit;
    logic [4:0] res_dmg;
    logic       game_over;
    logic       winner;

    attack_resolver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .new_game  (new_game),
        .atk_valid (atk_valid),
        .atk_ready (atk_ready),
        .dmg       (dmg),
        .accu      (accu),
        .turn      (turn),
        .p1_hp     (p1_hp),
        .p2_hp     (p2_hp),
        .res_valid (res_valid),
        .res_hit   (res_hit),
        .res_crit  (res_crit),
        .res_dmg   (res_dmg),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Game model: HP per player, whose turn it is, and end-of-game state.
    int hp_m[2];
    int turn_m;
    bit over_m;
    int winner_m;

    // Random source model: x^8+x^6+x^5+x^4+1, seeded with A5 by reset.
    logic [7:0] m_lfsr;

    function automatic logic [7:0] m_step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= m_step(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hp_m[0]  = 40;
        hp_m[1]  = 40;
        turn_m   = 0;
        over_m   = 1'b0;
        winner_m = 0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_p1hp"}, p1_hp, hp_m[0]);
        chk({tag, "_p2hp"}, p2_hp, hp_m[1]);
        chk({tag, "_turn"}, turn, turn_m);
        chk({tag, "_over"}, game_over, over_m);
        chk({tag, "_ready"}, atk_ready, !over_m);
        chk({tag, "_winner"}, winner, winner_m);
    endtask

    // Called #1 after a clock edge; issues one move and follows it to completion.
    task automatic do_move(input int d, input int a);
        logic [3:0] rnd, hi;
        bit hit, crit;
        int req, def;
        chk("mv_ready", atk_ready, 1);
        atk_valid = 1'b1;
        dmg  = d[3:0];
        accu = a[3:0];
        @(posedge clk); #1;
        atk_valid = 1'b0;
        rnd  = m_lfsr[3:0];
        hi   = m_lfsr[7:4];
        hit  = (int'(rnd) <= a);
        crit = CRIT_EN && hit && (hi == 4'hF);
        req  = !hit ? 0 : (crit ? 2 * d : d);
        def  = (turn_m == 0) ? 1 : 0;
        hp_m[def] = (hp_m[def] > req) ? hp_m[def] - req : 0;
        chk("mv_rv_n0", res_valid, 0);
        chk("mv_busy", atk_ready, 0);
        @(posedge clk); #1;
        chk("mv_rv_n1", res_valid, 0);
        @(posedge clk); #1;
        chk("mv_rv_strobe", res_valid, 1);
        chk("mv_hit", res_hit, hit);
        chk("mv_crit", res_crit, crit);
        chk("mv_dmg", res_dmg, req);
        chk("mv_p1hp", p1_hp, hp_m[0]);
        chk("mv_p2hp", p2_hp, hp_m[1]);
        @(posedge clk); #1;
        chk("mv_rv_after", res_valid, 0);
        if (hp_m[def] == 0) begin
            over_m   = 1'b1;
            winner_m = turn_m;
        end
        turn_m = 1 - turn_m;
        chk_state("mv_end");
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_reset();
        chk("ng_rv", res_valid, 0);
        chk_state("ng");
    endtask

    task automatic watch_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk(tag, res_valid, 0);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset values
        chk("rst_rv", res_valid, 0);
        chk("rst_hit", res_hit, 0);
        chk("rst_crit", res_crit, 0);
        chk("rst_dmg", res_dmg, 0);
        chk_state("rst");

        // Always-hit single move
        do_move(1, 15);

        // Accuracy 0: hit only when the modelled roll is 0
        for (int i = 0; i < 4; i++) do_move($urandom_range(1, 15), 0);

        // Randomized moves, restarting whenever the game ends
        for (int i = 0; i < 14; i++) begin
            if (over_m) do_new_game();
            do_move($urandom_range(0, 15), $urandom_range(0, 15));
        end

        // Zero damage that always hits leaves HP untouched
        if (over_m) do_new_game();
        do_move(0, 15);

        // new_game while the move is in ROLL aborts it
        do_new_game();
        atk_valid = 1'b1; dmg = 4'd7; accu = 4'd15;
        @(posedge clk); #1;
        atk_valid = 1'b0;
        chk("roll_busy", atk_ready, 0);
        do_new_game();
        watch_quiet("roll_abort_rv", 4);
        chk_state("roll_abort");

        // new_game on the same edge as an offered move drops the move
        atk_valid = 1'b1; new_game = 1'b1; dmg = 4'd5; accu = 4'd15;
        @(posedge clk); #1;
        atk_valid = 1'b0; new_game = 1'b0;
        model_reset();
        chk("coinc_ready", atk_ready, 1);
        watch_quiet("coinc_rv", 4);
        chk_state("coinc");

        // Asynchronous reset asserted mid-cycle during an attack
        do_move(3, 15);
        atk_valid = 1'b1; dmg = 4'd4; accu = 4'd15;
        @(posedge clk); #1;
        atk_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_rv", res_valid, 0);
        chk_state("arst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        watch_quiet("arst_rv_after", 3);
        chk_state("arst_after");

`ifdef PBS_CRIT_EN
        // Wait until the next roll's upper nibble is F, then force a hit
        begin
            logic [7:0] nxt;
            for (int i = 0; i < 300; i++) begin
                nxt = m_step(m_lfsr);
                if (nxt[7:4] == 4'hF) break;
                @(posedge clk); #1;
            end
            nxt = m_step(m_lfsr);
            chk("crit_window", nxt[7:4], 4'hF);
            do_move(9, 15);
            chk("crit_flag", res_crit, 1);
            chk("crit_dmg", res_dmg, 18);
        end
        do_new_game();
`endif

        // Saturation and game end: P1 hits for 9, P2 for 1
        do_new_game();
        for (int k = 0; k < 20 && !over_m; k++) do_move((turn_m == 0) ? 9 : 1, 15);
        chk("end_over", game_over, 1);
        chk("end_winner", winner, 0);
        chk("end_p2hp", p2_hp, 0);
        chk("end_ready", atk_ready, 0);

        // Moves offered while over are ignored
        atk_valid = 1'b1; dmg = 4'd9; accu = 4'd15;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("over_rv", res_valid, 0);
        end
        atk_valid = 1'b0;
        chk_state("over_hold");

        // new_game clears the finished game
        do_new_game();
        do_move(2, 15);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/attack_resolver.md
# attack_resolver

Sequential attack-resolution stage directly downstream of the move decoder. It accepts one decoded move per turn: 4-bit damage and 4-bit accuracy for the current attacker. It rolls a pseudo-random hit check, applies saturating damage to the defender's HP, reports the result, alternates turns, and declares the winner when an HP reaches zero.

## Interface
- HP_W, 8, width of HP registers
- MAX_HP, 40, HP loaded at reset and on new_game
- LFSR_SEED, 8'hA5, LFSR value at reset (must be non-zero)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- new_game  in  1  synchronous restart: reload HP, clear turn, abort in-flight attack
- atk_valid  in  1  move present on dmg/accu
- atk_ready  out  1  resolver can accept a move
- dmg  in  4  damage of attacker's move
- accu  in  4  accuracy of attacker's move, 15 = always hits
- turn  out  1  current attacker, 0 = player 1, 1 = player 2
- p1_hp, p2_hp  out  HP_W  current HP
- res_valid  out  1  one-cycle result strobe
- res_hit  out  1  attack hit, valid with res_valid
- res_crit  out  1  critical hit, valid with res_valid
- res_dmg  out  5  damage actually requested: 0 on miss
- game_over  out  1  a player's HP is 0
- winner  out  1  attacker that finished the game, valid while game_over

## Operation
- 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifts every cycle including while idle.
- rnd = lfsr[3:0], sampled in ROLL.
- FSM states:
  - IDLE: atk_ready=1. On atk_valid&&atk_ready, capture dmg/accu and go to ROLL.
  - ROLL: hit = (rnd <= accu). Go to APPLY.
  - APPLY: defender HP = max(hp − res_dmg, 0), saturating at 0, no wrap. Go to REPORT.
  - REPORT: res_valid=1 for this cycle only, toggle turn. If defender HP == 0, go to OVER and set winner = attacker; else go to IDLE.
  - OVER: game_over=1, atk_ready=0. Incoming moves are ignored.
- atk_ready is Moore, driven by state only.
- res_dmg = hit ? dmg : 0, zero-extended. With crit (see Configuration) res_dmg = dmg<<1.
- res_hit, res_crit and res_dmg hold their last values between strobes.
- new_game is sampled in any state and has priority over everything else:
  - HP set to MAX_HP, turn=0, game_over=0, winner=0.
  - State returns to IDLE; the aborted attack produces no res_valid.
  - The LFSR is not reseeded.
- Reset values: state IDLE, p1_hp=p2_hp=MAX_HP, turn=0, res_valid=res_hit=res_crit=0, res_dmg=0, game_over=0, winner=0, lfsr=LFSR_SEED. atk_ready=1 after reset.

## Timing
- Move accepted at edge N; ROLL at N+1; APPLY at N+2; res_valid high in cycle N+3 with HP already updated.
- Throughput: one move per 4 cycles. atk_ready returns at N+4, or stays low in OVER.
- dmg=0 is legal: res_hit may be 1 with no HP change.
- new_game coinciding with an accepted atk_valid: new_game wins and the move is dropped.

## Configuration
- PBS_CRIT_EN defined: on a hit where lfsr[7:4]==4'hF in ROLL, res_crit=1 and damage is doubled (max 30).
- PBS_CRIT_EN undefined: res_crit is tied 0, res_dmg[4]=0, no crit logic is synthesized.

## Structure
- Package pbs_pkg holds:
  - state enum (IDLE, ROLL, APPLY, REPORT, OVER)
  - default HP_W, MAX_HP, LFSR_SEED
  - LFSR tap mask constant
- Sub-module pbs_lfsr8 (clk, rst_n, seed param, free-running 8-bit output).
- All remaining logic (FSM, HP registers, comparator, saturating subtractor) lives in attack_resolver.

## Test plan
- Reset: assert rst_n low mid-cycle, release -> p1_hp=p2_hp=40, turn=0, atk_ready=1, game_over=0, res_valid=0.
- Always-hit: dmg=1, accu=15 accepted at edge N -> res_valid only in cycle N+3, res_hit=1, res_dmg=1, p2_hp=39, turn=1.
- Miss/prediction: accu=0 with bench LFSR model from LFSR_SEED -> res_hit=1 iff modeled rnd==0, otherwise res_dmg=0 and HP unchanged.
- Saturation and game end:
  - Sequence: P1 dmg=9 accu=15, P2 dmg=1 accu=15, repeated.
  - Expected: after P1's 5th hit, p2_hp=0 (no wrap), game_over=1, winner=0, atk_ready=0.
  - A further atk_valid is ignored.
- new_game during ROLL -> no res_valid, HP=40/40, turn=0, atk_ready=1 next cycle; new_game in OVER clears game_over.
- PBS_CRIT_EN: force a modeled lfsr[7:4]==F hit with dmg=9, accu=15 -> res_crit=1, res_dmg=18, defender HP −18; without the macro, res_crit stays 0 throughout.
